// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/exec/mem/writeback
// and drives ALU select, memory requests and datapath enables from the latched IR.
module rv_multicycle_ctrl #(
    parameter int unsigned IMEM_TIMEOUT  = 0,
    parameter bit          RESET_TO_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic [2:0]  alu_fn,
    output logic        alu_alt,
    output logic        alu_src_imm,
    output logic        alu_src_pc,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [31:0] ir,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [2:0] AluAddSub = 3'd0;
    localparam logic [2:0] AluSrlSra = 3'd5;

    localparam int unsigned   CntW    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(IMEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt, StTrap
    } state_e;

    localparam state_e ResetState = RESET_TO_HALT ? StHalt : StFetch;

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [1:0]      fault_q, fault_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fetch_req, in_halt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_alt;
    logic       is_r, is_imm, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, is_sys;
    logic       legal;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign f7_alt   = ir_q[30];
    assign is_r     = (opcode == OpR);
    assign is_imm   = (opcode == OpImm);
    assign is_load  = (opcode == OpLoad);
    assign is_store = (opcode == OpStore);
    assign is_br    = (opcode == OpBranch);
    assign is_jal   = (opcode == OpJal);
    assign is_jalr  = (opcode == OpJalr);
    assign is_lui   = (opcode == OpLui);
    assign is_auipc = (opcode == OpAuipc);
    assign is_sys   = (opcode == OpSystem);
    assign legal    = is_r | is_imm | is_load | is_store | is_br | is_jal | is_jalr |
                      is_lui | is_auipc | is_sys;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ResetState;
            ir_q    <= '0;
            fault_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        fault_d     = fault_q;
        cnt_d       = '0;
        fetch_req   = 1'b0;
        in_halt     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_fn      = AluAddSub;
        alu_alt     = 1'b0;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        unique case (state_q)
            StFetch: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end else if (IMEM_TIMEOUT != 0 && cnt_q == CntLast) begin
                    fault_d = 2'd2;
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                if (is_sys) begin
                    state_d = StHalt;
                end else if (!legal) begin
                    fault_d = 2'd1;
                    state_d = StTrap;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_r || is_imm) begin
                    alu_fn  = funct3;
                    // IMM ADD has no subtract form; only the shift uses bit 30 there.
                    alu_alt = f7_alt & ((funct3 == AluSrlSra) | (is_r & (funct3 == AluAddSub)));
                end
                alu_src_imm = is_imm | is_load | is_store | is_jalr | is_jal | is_auipc | is_br;
                alu_src_pc  = is_jal | is_auipc | is_br;
                state_d     = (is_load || is_store) ? StMem : StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_we   = 1'b1;
                pc_sel  = is_jal | is_jalr | (is_br & br_taken);
                rf_we   = is_r | is_imm | is_load | is_lui | is_auipc | is_jal | is_jalr;
                wb_sel  = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
                state_d = StFetch;
            end
            StHalt: in_halt = 1'b1;
            StTrap: ;
            default: state_d = StTrap;
        endcase
    end

    // Reset forces the state to its reset value asynchronously; gating keeps outputs low while
    // rst_n is held.
    assign imem_req = fetch_req & rst_n;
    assign halted   = in_halt & rst_n;
    assign ir       = ir_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized self-checking bench for rv_multicycle_ctrl with an instruction-level reference
// model; a second instance with the timeout disabled checks that FETCH can wait forever.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, instr_valid, dmem_req, dmem_we, dmem_ready, br_taken;
    logic [31:0] instr, ir;
    logic [2:0]  alu_fn;
    logic        alu_alt, alu_src_imm, alu_src_pc, rf_we, pc_we, pc_sel, halted;
    logic [1:0]  wb_sel, fault;

    logic        imem_req0, dmem_req0, dmem_we0, alu_alt0, alu_src_imm0, alu_src_pc0;
    logic        rf_we0, pc_we0, pc_sel0, halted0;
    logic [2:0]  alu_fn0;
    logic [1:0]  wb_sel0, fault0;
    logic [31:0] ir0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.IMEM_TIMEOUT(8), .RESET_TO_HALT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .instr_valid(instr_valid),
        .instr(instr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .br_taken(br_taken), .alu_fn(alu_fn), .alu_alt(alu_alt), .alu_src_imm(alu_src_imm),
        .alu_src_pc(alu_src_pc), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
        .pc_sel(pc_sel), .ir(ir), .halted(halted), .fault(fault)
    );

    rv_multicycle_ctrl #(.IMEM_TIMEOUT(0), .RESET_TO_HALT(1'b0)) u_dut_notmo (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req0), .instr_valid(1'b0),
        .instr(32'd0), .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_ready(1'b0),
        .br_taken(1'b0), .alu_fn(alu_fn0), .alu_alt(alu_alt0), .alu_src_imm(alu_src_imm0),
        .alu_src_pc(alu_src_pc0), .rf_we(rf_we0), .wb_sel(wb_sel0), .pc_we(pc_we0),
        .pc_sel(pc_sel0), .ir(ir0), .halted(halted0), .fault(fault0)
    );

    typedef enum int {CR, CI, CL, CS, CB, CJal, CJalr, CLui, CAuipc, CSys, CBad} cls_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cls_e classify(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return CR;
            7'b0010011: return CI;
            7'b0000011: return CL;
            7'b0100011: return CS;
            7'b1100011: return CB;
            7'b1101111: return CJal;
            7'b1100111: return CJalr;
            7'b0110111: return CLui;
            7'b0010111: return CAuipc;
            7'b1110011: return CSys;
            default:    return CBad;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(input cls_e c);
        logic [31:0] body;
        logic [6:0]  op;
        body = $urandom;
        case (c)
            CR:      op = 7'b0110011;
            CI:      op = 7'b0010011;
            CL:      op = 7'b0000011;
            CS:      op = 7'b0100011;
            CB:      op = 7'b1100011;
            CJal:    op = 7'b1101111;
            CJalr:   op = 7'b1100111;
            CLui:    op = 7'b0110111;
            CAuipc:  op = 7'b0010111;
            CSys:    op = 7'b1110011;
            default: begin
                op = 7'($urandom);
                while (classify({25'd0, op}) != CBad) op = 7'($urandom);
            end
        endcase
        return {body[31:7], op};
    endfunction

    // Expected ALU controls in EXEC: {fn, alt, src_imm, src_pc}
    function automatic logic [5:0] exp_alu(input logic [31:0] i);
        cls_e       c;
        logic [2:0] f3;
        logic       alt, imm, pc;
        logic [2:0] fn;
        c  = classify(i);
        f3 = i[14:12];
        fn = 3'd0; alt = 1'b0; imm = 1'b0; pc = 1'b0;
        case (c)
            CR:  begin fn = f3; alt = i[30] && (f3 == 3'd0 || f3 == 3'd5); end
            CI:  begin fn = f3; alt = i[30] && (f3 == 3'd5); imm = 1'b1; end
            CL, CS, CJalr:     imm = 1'b1;
            CJal, CAuipc, CB:  begin imm = 1'b1; pc = 1'b1; end
            default: ;
        endcase
        return {fn, alt, imm, pc};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0; instr = '0;
        #1;
        check("rst_outs", {imem_req, dmem_req, dmem_we, alu_fn, alu_alt, alu_src_imm, alu_src_pc,
                           rf_we, wb_sel, pc_we, pc_sel, halted, fault}, 32'd0);
        check("rst_ir", ir, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered and left at a negedge with the DUT in FETCH (unless it halts or traps).
    task automatic run_instr(input logic [31:0] i, input int fwait, input int mcyc, input logic br);
        cls_e c;
        logic is_mem;
        c = classify(i);
        is_mem = (c == CL) || (c == CS);
        for (int k = 0; k < fwait; k++) begin
            instr_valid = 1'b0; instr = $urandom; #1;
            check("fetch_wait_req", imem_req, 1);
            @(negedge clk);
        end
        instr_valid = 1'b1; instr = i; #1;
        check("fetch_req", imem_req, 1);
        check("fetch_no_dmem", dmem_req, 0);
        @(negedge clk);
        instr_valid = 1'($urandom); instr = $urandom; dmem_ready = 1'($urandom); #1;
        check("decode_ir", ir, i);
        check("decode_idle", {imem_req, dmem_req, rf_we, pc_we}, 0);
        @(negedge clk);
        instr_valid = 1'($urandom); dmem_ready = 1'($urandom); #1;
        if (c == CSys) begin
            for (int k = 0; k < 3; k++) begin
                check("halt_halted", halted, 1);
                check("halt_quiet", {imem_req, dmem_req, rf_we, pc_we, fault}, 0);
                @(negedge clk);
                instr_valid = 1'($urandom); #1;
            end
            return;
        end
        if (c == CBad) begin
            for (int k = 0; k < 3; k++) begin
                check("trap_fault", fault, 1);
                check("trap_quiet", {imem_req, dmem_req, rf_we, pc_we, halted}, 0);
                @(negedge clk);
                instr_valid = 1'($urandom); #1;
            end
            return;
        end
        check("exec_alu", {alu_fn, alu_alt, alu_src_imm, alu_src_pc}, exp_alu(i));
        check("exec_idle", {imem_req, dmem_req, rf_we, pc_we}, 0);
        @(negedge clk);
        if (is_mem) begin
            for (int m = 1; m <= mcyc; m++) begin
                dmem_ready = (m == mcyc); instr_valid = 1'($urandom); #1;
                check("mem_req", dmem_req, 1);
                check("mem_we", dmem_we, (c == CS));
                check("mem_idle", {imem_req, rf_we, pc_we}, 0);
                @(negedge clk);
            end
        end
        dmem_ready = 1'($urandom); br_taken = br; instr_valid = 1'($urandom); #1;
        check("wb_pc_we", pc_we, 1);
        check("wb_pc_sel", pc_sel, (c == CJal) || (c == CJalr) || (c == CB && br));
        check("wb_rf_we", rf_we, (c == CR) || (c == CI) || (c == CL) || (c == CLui) ||
                                 (c == CAuipc) || (c == CJal) || (c == CJalr));
        check("wb_sel", wb_sel, (c == CL) ? 1 : (c == CJal || c == CJalr) ? 2 :
                                (c == CLui) ? 3 : 0);
        check("wb_idle", {imem_req, dmem_req}, 0);
        @(negedge clk);
        br_taken = 1'($urandom);
    endtask

    initial begin
        cls_e c;
        @(negedge clk);
        do_reset();

        run_instr(32'h002081B3, 0, 1, 1'b0);   // ADD
        run_instr(32'h402081B3, 0, 1, 1'b0);   // SUB
        run_instr(32'h40000093, 1, 1, 1'b0);   // ADDI with bit 30 set
        run_instr(32'h0000A283, 0, 3, 1'b0);   // LW, 3 MEM cycles
        run_instr(32'h0050A223, 2, 1, 1'b0);   // SW
        run_instr(32'h00000463, 0, 1, 1'b1);   // BEQ taken
        run_instr(32'h00000073, 0, 1, 1'b0);   // ECALL
        do_reset();
        run_instr(32'hFFFFFFFF, 0, 1, 1'b0);   // illegal
        do_reset();

        // Reset asserted in the middle of a MEM wait
        instr_valid = 1'b1; instr = 32'h0000A283;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); dmem_ready = 1'b0; #1;
        check("midmem_req", dmem_req, 1);
        #2 rst_n = 1'b0; #1;
        check("midmem_rst_req", dmem_req, 0);
        check("midmem_rst_ir", ir, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            c = cls_e'($urandom_range(0, 10));
            run_instr(make_instr(c), $urandom_range(0, 5), $urandom_range(1, 4), 1'($urandom));
            if (c == CSys || c == CBad) do_reset();
        end

        // Fetch timeout: 8 FETCH cycles with no response
        do_reset();
        for (int k = 0; k < 8; k++) begin
            instr_valid = 1'b0; #1;
            check("tmo_wait_req", imem_req, 1);
            check("tmo_wait_fault", fault, 0);
            @(negedge clk);
        end
        for (int k = 0; k < 12; k++) begin
            #1;
            check("tmo_fault", fault, 2);
            check("tmo_quiet", {imem_req, halted}, 0);
            @(negedge clk);
            instr_valid = 1'($urandom);
        end
        check("notmo_fault", fault0, 0);
        check("notmo_req", imem_req0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
